// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-wide data memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned HALF_W     = 16;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_SIZE * 4);
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t              state, state_d;
    logic                req_ready_d, rsp_valid_d, rsp_err_d, mem_we_d;
    logic [31:0]         rsp_rdata_d, mem_addr_d, mem_wdata_d;
    logic                lat_we, lat_we_d, lat_unsigned, lat_unsigned_d;
    logic [1:0]          lat_size, lat_size_d, lat_lane, lat_lane_d;
    logic [HALF_W-1:0]   lat_wdata, lat_wdata_d;
    logic                req_err_c;
    logic [31:0]         shifted_c, load_c, merged_c;

    // Request legality, evaluated on the accept edge
    always_comb begin
        req_err_c = 1'b0;
        if (req_size == 2'b11)                                req_err_c = 1'b1;
        if (req_size == SIZE_HALF && req_addr[0] != 1'b0)     req_err_c = 1'b1;
        if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)  req_err_c = 1'b1;
        if (req_addr >= ADDR_LIMIT)                           req_err_c = 1'b1;
    end

    // Load lane extraction/extension and sub-word store merge
    always_comb begin
        shifted_c = mem_rdata >> {lat_lane, 3'b000};
        load_c    = mem_rdata;
        merged_c  = mem_rdata;
        case (lat_size)
            SIZE_BYTE: load_c = lat_unsigned ? {24'd0, shifted_c[7:0]}
                                             : {{24{shifted_c[7]}}, shifted_c[7:0]};
            SIZE_HALF: load_c = lat_unsigned ? {16'd0, shifted_c[15:0]}
                                             : {{16{shifted_c[15]}}, shifted_c[15:0]};
            default:   load_c = mem_rdata;
        endcase
        if (lat_size == SIZE_BYTE) begin
            case (lat_lane)
                2'd0:    merged_c = {mem_rdata[31:8], lat_wdata[7:0]};
                2'd1:    merged_c = {mem_rdata[31:16], lat_wdata[7:0], mem_rdata[7:0]};
                2'd2:    merged_c = {mem_rdata[31:24], lat_wdata[7:0], mem_rdata[15:0]};
                default: merged_c = {lat_wdata[7:0], mem_rdata[23:0]};
            endcase
        end else begin
            merged_c = lat_lane[1] ? {lat_wdata, mem_rdata[15:0]}
                                   : {mem_rdata[31:16], lat_wdata};
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        req_ready_d    = req_ready;
        rsp_valid_d    = 1'b0;
        rsp_err_d      = rsp_err;
        rsp_rdata_d    = rsp_rdata;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr;
        mem_wdata_d    = mem_wdata;
        lat_we_d       = lat_we;
        lat_size_d     = lat_size;
        lat_unsigned_d = lat_unsigned;
        lat_lane_d     = lat_lane;
        lat_wdata_d    = lat_wdata;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    req_ready_d    = 1'b0;
                    lat_we_d       = req_we;
                    lat_size_d     = req_size;
                    lat_unsigned_d = req_unsigned;
                    lat_lane_d     = req_addr[1:0];
                    lat_wdata_d    = req_wdata[HALF_W-1:0];
                    if (req_err_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d    = ACCESS;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                        if (req_we && req_size == SIZE_WORD) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = req_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (lat_we && lat_size != SIZE_WORD) begin
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged_c;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = lat_we ? 32'd0 : load_c;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'd0;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= 32'd0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_lane     <= 2'b00;
            lat_wdata    <= '0;
        end else begin
            state        <= state_d;
            req_ready    <= req_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_err      <= rsp_err_d;
            rsp_rdata    <= rsp_rdata_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            lat_we       <= lat_we_d;
            lat_size     <= lat_size_d;
            lat_unsigned <= lat_unsigned_d;
            lat_lane     <= lat_lane_d;
            lat_wdata    <= lat_wdata_d;
        end
    end
endmodule
